apb_ram_slave_p: RTL



---
 rtl/apb_ram_pkg.sv | 27 ++
 rtl/apb_ram_mem.sv | 34 +++
 rtl/apb_ram_slave_p.sv | 94 +++++++++
 3 files changed

// File: rtl/apb_ram_pkg.sv
// Shared types and helpers for the parametrised APB4 RAM slave.
package apb_ram_pkg;

    // Transfer FSM: waiting for a setup phase, or inside the access phase.
    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    // Number of byte-offset address bits for a given data width.
    function automatic int unsigned off_bits(input int unsigned data_w);
        return (data_w > 8) ? $clog2(data_w / 8) : 0;
    endfunction

    // Out-of-range or misaligned byte address.
    function automatic logic addr_err(input logic [31:0] paddr, input int unsigned depth,
                                      input int unsigned bytes);
        logic [32:0] limit;
        logic        oor;
        logic        mis;
        limit = 33'(depth) * 33'(bytes);
        oor   = ({1'b0, paddr} >= limit);
        mis   = ((paddr & (bytes - 32'd1)) != 32'd0);
        return oor | mis;
    endfunction

endpackage

// File: rtl/apb_ram_mem.sv
// DEPTH x DATA_W storage with per-byte synchronous write and combinational read.
module apb_ram_mem
    import apb_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    localparam int unsigned BYTES = DATA_W / 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BYTES-1:0]  wstrb,
    output logic [DATA_W-1:0] rdata
);

    // No reset: contents survive a bus reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Byte-lane masked write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (wstrb[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/apb_ram_slave_p.sv
// APB4 RAM slave: configurable width, depth and wait states, byte strobes, PSLVERR.
module apb_ram_slave_p
    import apb_ram_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic [31:0]         paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF   = off_bits(DATA_W);
    localparam int unsigned AW    = $clog2(DEPTH);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              wr_q;
    logic              err_q;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BYTES-1:0]  strb_q;
    logic [DATA_W-1:0] prdata_q;

    logic [AW-1:0]     paddr_idx;
    logic              setup_err;
    logic              setup;
    logic              complete;
    logic              mem_we;
    logic [AW-1:0]     mem_idx;
    logic [DATA_W-1:0] mem_rdata;

    assign paddr_idx = paddr[OFF +: AW];
    assign setup_err = addr_err(paddr, DEPTH, BYTES);
    // psel without penable is a setup phase in either state; in ACCESS it restarts the transfer.
    assign setup     = psel & ~penable;
    assign pready    = (state_q == StAccess) && (cnt_q == 4'd0);
    assign complete  = pready & psel & penable;
    assign mem_we    = presetn & complete & wr_q & ~err_q;
    // The single port reads at the setup address except while committing a write.
    assign mem_idx   = mem_we ? idx_q : paddr_idx;
    assign pslverr   = pready & err_q;
    assign prdata    = prdata_q;

    apb_ram_mem #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk  (pclk),
        .we   (mem_we),
        .idx  (mem_idx),
        .wdata(wdata_q),
        .wstrb(strb_q),
        .rdata(mem_rdata)
    );

    // Transfer FSM: capture at setup, count wait states, release at completion or abort.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else if (setup) begin
            state_q  <= StAccess;
            wr_q     <= pwrite;
            idx_q    <= paddr_idx;
            wdata_q  <= pwdata;
            strb_q   <= pstrb;
            err_q    <= setup_err;
            cnt_q    <= 4'(WAIT_STATES);
            prdata_q <= (pwrite || setup_err) ? '0 : mem_rdata;
        end else if (state_q == StAccess) begin
            // Here psel implies penable, so pready with psel is the completion edge.
            if (!psel || pready) begin
                state_q  <= StIdle;
                prdata_q <= '0;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

endmodule
